// File: rtl/key_step_debouncer.sv
// Two-channel pushbutton debouncer that turns key presses into one-clock step strobes.
// Channel 0 can instead be driven by a free-running auto-run divider.
module key_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  input  logic       run_sw,
  output logic [1:0] step_pulse,
  output logic [1:0] key_level,
  output logic [3:0] state_dbg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]          key_meta_q;
  logic [1:0]          key_sync_q;
  logic                run_meta_q;
  logic                run_q;

  logic [1:0][1:0]     st_q;
  logic [1:0][1:0]     st_d;
  logic [1:0][CW-1:0]  cnt_q;
  logic [1:0][CW-1:0]  cnt_d;
  logic [1:0]          accept_q;
  logic [1:0]          accept_d;

  logic [DW-1:0]       div_q;
  logic [DW-1:0]       div_d;
  logic                wrap;

  logic [1:0]          pulse_q;
  logic [1:0]          pulse_d;
  logic [1:0]          level_q;

  // Synchronizers hold the inverted key so reset value 0 means released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
      run_meta_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      key_meta_q <= ~key_n;
      key_sync_q <= key_meta_q;
      run_meta_q <= run_sw;
      run_q      <= run_meta_q;
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    accept_d = '0;
    for (int i = 0; i < 2; i++) begin
      unique case (st_q[i])
        IDLE: begin
          if (key_sync_q[i]) begin
            st_d[i]  = PRESS_WAIT;
            cnt_d[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_sync_q[i]) begin
            st_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]     = PRESSED;
            accept_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        PRESSED: begin
          if (!key_sync_q[i]) begin
            st_d[i]  = RELEASE_WAIT;
            cnt_d[i] = '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_sync_q[i]) begin
            st_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // Divider is held at zero while auto-run is off
  always_comb begin
    div_d = '0;
    wrap  = 1'b0;
    if (run_q) begin
      if (div_q == DIV_LAST) begin
        wrap = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_comb begin
    pulse_d    = '0;
    pulse_d[1] = accept_q[1];
    pulse_d[0] = run_q ? wrap : accept_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= '0;
      cnt_q    <= '0;
      accept_q <= '0;
      div_q    <= '0;
      pulse_q  <= '0;
      level_q  <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      div_q    <= div_d;
      pulse_q  <= pulse_d;
      level_q  <= {st_q[1][1], st_q[0][1]};
    end
  end

  assign step_pulse = pulse_q;
  assign key_level  = level_q;
  assign state_dbg  = {st_q[1], st_q[0]};

endmodule

// File: tb/tb_key_step_debouncer.sv
// Bench for key_step_debouncer with DEBOUNCE_CYCLES=4, RUN_DIV=8.
// Cycle k below means the k-th rising edge of the scenario; outputs checked 1ns after it.
module tb_key_step_debouncer;

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic       run_sw;
  logic [1:0] step_pulse;
  logic [1:0] key_level;
  logic [3:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  key_step_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .run_sw    (run_sw),
    .step_pulse(step_pulse),
    .key_level (key_level),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pulse;
    logic       chk_ls;
    logic [1:0] level;
    logic [3:0] state;
  } exp_t;

  typedef struct {
    logic       kn0;
    logic [1:0] pulse;
    logic [1:0] level;
    logic [3:0] state;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[18];

  function automatic vec_t mk(logic kn0, logic [1:0] p,
                              logic [1:0] l, logic [3:0] s);
    vec_t v;
    v.kn0   = kn0;
    v.pulse = p;
    v.level = l;
    v.state = s;
    return v;
  endfunction

  task automatic check(input string tag, input int k);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s[%0d] scoreboard empty", tag, k);
      return;
    end
    e = sbq.pop_front();
    n_tests++;
    if (step_pulse !== e.pulse) begin
      n_fail++;
      $display("FAIL %s[%0d] step_pulse got %b want %b",
               tag, k, step_pulse, e.pulse);
    end
    if (e.chk_ls) begin
      n_tests++;
      if (key_level !== e.level) begin
        n_fail++;
        $display("FAIL %s[%0d] key_level got %b want %b",
                 tag, k, key_level, e.level);
      end
      n_tests++;
      if (state_dbg !== e.state) begin
        n_fail++;
        $display("FAIL %s[%0d] state_dbg got %h want %h",
                 tag, k, state_dbg, e.state);
      end
    end
  endtask

  task automatic step(input logic [1:0] kn, input logic rs, input logic r,
                      input logic [1:0] p, input logic ls,
                      input logic [1:0] lv, input logic [3:0] st,
                      input string tag, input int k);
    exp_t e;
    key_n  = kn;
    run_sw = rs;
    rst    = r;
    e.pulse  = p;
    e.chk_ls = ls;
    e.level  = lv;
    e.state  = st;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check(tag, k);
    rst = 1'b0;
  endtask

  task automatic stp(input logic [1:0] kn, input logic rs,
                     input logic [1:0] p, input string tag, input int k);
    step(kn, rs, 1'b0, p, 1'b0, 2'b00, 4'h0, tag, k);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++)
      stp(2'b11, 1'b0, 2'b00, tag, k);
    step(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 4'h0, tag, n);
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 2'b00, 2'b00, 4'h0);
    tbl[1]  = mk(1'b0, 2'b00, 2'b00, 4'h0);
    tbl[2]  = mk(1'b0, 2'b00, 2'b00, 4'h1);
    tbl[3]  = mk(1'b0, 2'b00, 2'b00, 4'h1);
    tbl[4]  = mk(1'b0, 2'b00, 2'b00, 4'h1);
    tbl[5]  = mk(1'b0, 2'b00, 2'b00, 4'h1);
    tbl[6]  = mk(1'b0, 2'b00, 2'b00, 4'h2);
    tbl[7]  = mk(1'b0, 2'b01, 2'b01, 4'h2);
    tbl[8]  = mk(1'b0, 2'b00, 2'b01, 4'h2);
    tbl[9]  = mk(1'b0, 2'b00, 2'b01, 4'h2);
    tbl[10] = mk(1'b1, 2'b00, 2'b01, 4'h2);
    tbl[11] = mk(1'b1, 2'b00, 2'b01, 4'h2);
    tbl[12] = mk(1'b1, 2'b00, 2'b01, 4'h3);
    tbl[13] = mk(1'b1, 2'b00, 2'b01, 4'h3);
    tbl[14] = mk(1'b1, 2'b00, 2'b01, 4'h3);
    tbl[15] = mk(1'b1, 2'b00, 2'b01, 4'h3);
    tbl[16] = mk(1'b1, 2'b00, 2'b01, 4'h0);
    tbl[17] = mk(1'b1, 2'b00, 2'b00, 4'h0);

    rst    = 1'b1;
    key_n  = 2'b00;
    run_sw = 1'b1;
    for (int k = 0; k < 3; k++)
      step(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 4'h0, "reset", k);
    idle(4, "post_reset");

    for (int k = 0; k < 18; k++)
      step({1'b1, tbl[k].kn0}, 1'b0, 1'b0, tbl[k].pulse, 1'b1,
           tbl[k].level, tbl[k].state, "clean", k);
    idle(4, "clean_idle");

    for (int k = 0; k < 16; k++)
      stp({1'b1, (k == 2)}, 1'b0, (k == 10) ? 2'b01 : 2'b00, "bounce", k);
    idle(10, "bounce_idle");

    for (int k = 0; k < 22; k++) begin
      if (k < 8)
        stp({1'b1, (k == 10 || k == 11)}, 1'b0,
            (k == 7) ? 2'b01 : 2'b00, "relbounce", k);
      else
        step({1'b1, (k == 10 || k == 11)}, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01,
             (k == 12 || k == 13) ? 4'h3 : 4'h2, "relbounce", k);
    end
    idle(10, "relbounce_idle");

    for (int k = 0; k < 10; k++)
      stp(2'b00, 1'b0, (k == 7) ? 2'b11 : 2'b00, "both", k);
    idle(10, "both_idle");

    for (int k = 0; k < 60; k++) begin
      logic       held;
      logic [1:0] p;
      held = (k >= 12 && k <= 25);
      p    = 2'b00;
      if (k == 9 || k == 17 || k == 25 || k == 33 || k == 41) p[0] = 1'b1;
      if (k == 19) p[1] = 1'b1;
      if (k == 22)
        step({~held, ~held}, (k < 40), 1'b0, p, 1'b1, 2'b11, 4'hA,
             "autorun", k);
      else
        stp({~held, ~held}, (k < 40), p, "autorun", k);
    end
    idle(4, "autorun_idle");

    for (int k = 0; k < 22; k++) begin
      if (k == 5)
        step(2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 4'h0, "rst_mid", k);
      else
        stp(2'b10, 1'b0, (k == 13) ? 2'b01 : 2'b00, "rst_mid", k);
    end
    idle(10, "rst_mid_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_step_debouncer.md
KEY_STEP_DEBOUNCER -- requirements
Module: key_step_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of clocks a raw key level must hold stable to be accepted (10 ms at 50 MHz).
REQ-002 Parameter RUN_DIV, default 5000000, SHALL set the auto-run step period in clocks (10 Hz at 50 MHz).
REQ-003 Port clk, input, 1, SHALL be the single system clock (50 MHz board oscillator); all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-005 Port key_n, input, 2, SHALL carry the raw board pushbuttons (active-low, asynchronous, bouncing); bit 0 = processor step, bit 1 = register-read step.
REQ-006 Port run_sw, input, 1, SHALL select auto-run (1) or manual single-step (0); it is asynchronous.
REQ-007 Port step_pulse, output, 2, SHALL carry one-clock-wide registered step strobes, one per key, for the processor clk / clk_r enables.
REQ-008 Port key_level, output, 2, SHALL carry the debounced, active-high pressed level per key, for LED display.
REQ-009 Port state_dbg, output, 4, SHALL expose {ch1 state, ch0 state}, 2 bits each, encoded IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.

Function
REQ-010 Each key_n bit and run_sw SHALL pass through a two-flop synchronizer before any use; the inverted synchronized key is "pressed".
REQ-011 Each channel SHALL run an independent 4-state FSM with a stability counter sized for DEBOUNCE_CYCLES (no overflow or wrap at the terminal value).
REQ-012 IDLE: on pressed -> PRESS_WAIT, counter cleared to 0.
REQ-013 PRESS_WAIT: while pressed, counter +1 per clock; at count DEBOUNCE_CYCLES-1 -> PRESSED; if released before then -> IDLE with no pulse.
REQ-014 PRESSED: on released -> RELEASE_WAIT, counter cleared.
REQ-015 RELEASE_WAIT: while released, counter +1; at DEBOUNCE_CYCLES-1 -> IDLE; if pressed again -> PRESSED with no pulse.
REQ-016 key_level[i] SHALL be 1 exactly in PRESSED and RELEASE_WAIT.
REQ-017 step_pulse[i] SHALL assert for exactly one clock, on the clock after the PRESS_WAIT->PRESSED transition; one pulse per accepted press, regardless of hold time.
REQ-018 Latency: step_pulse SHALL rise DEBOUNCE_CYCLES+3 clocks after the first rising edge sampling a stably-low key_n.
REQ-019 Auto-run: while synchronized run_sw=1, a divider SHALL count 0..RUN_DIV-1 and wrap; step_pulse[0] SHALL assert for one clock each time the divider wraps to 0; channel-0 key presses SHALL NOT generate pulses (FSM still tracks, key_level[0] still valid).
REQ-020 Synchronized run_sw 0->1 SHALL clear the divider, so the first auto pulse occurs RUN_DIV clocks later; 1->0 SHALL stop pulses immediately, with no partial or extra pulse.
REQ-021 Channel 1 SHALL be unaffected by run_sw.
REQ-022 Simultaneous accepted presses on both keys SHALL produce both pulses in the same clock.

Reset
REQ-023 While rst=1, all FSMs SHALL be IDLE, counters and divider 0, synchronizers 0 (released), and step_pulse=0, key_level=0, state_dbg=0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort without a pulse; after release, a key still held SHALL be re-debounced from IDLE and produce exactly one pulse.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=8)
REQ-025 Clean press: key_n[0] low at cycle 0 and held -> step_pulse[0]=1 only in cycle 7; key_level[0]=1 from cycle 7.
REQ-026 Bounce: key_n[0] low 2 clocks, high 1, low and held -> no pulse in the bounce window; exactly one pulse 7 clocks after the final low edge.
REQ-027 Release bounce: while PRESSED, key_n[0] high 2 clocks, then low -> state returns to PRESSED, no second pulse, key_level stays 1.
REQ-028 Auto-run: run_sw=1 for 40 clocks -> step_pulse[0] every 8th clock (4-5 pulses, spaced exactly 8); key0 presses in that window give no pulse; run_sw=0 -> no further pulses.
REQ-029 Both keys pressed on the same edge -> step_pulse=2'b11 in a single cycle.
REQ-030 rst pulsed at cycle 5 of a held press -> no pulse; after rst release, exactly one pulse 7 clocks later.
